// File: rtl/axi_lite_slave_regfile.sv
// ---------------------------------------------------------------------------
// axi_lite_slave_regfile
//   AXI4-Lite responder in front of a bank of NUM_REGS read/write registers.
//   The write channel (AW/W/B) and read channel (AR/R) are independent FSMs,
//   so a read and a write can complete in the same cycle.
//
// Ports
//   axi_aclk, axi_areset      clock (rising edge), async active-high reset
//   s_axi_aw*/w*/b*           AXI-Lite write address / data / response
//   s_axi_ar*/r*              AXI-Lite read address / data
//   reg_out                   flat register contents, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//   reg_wr_pulse              one-cycle pulse on the bit of the register written
//
// Build option
//   AXI_LITE_SLV_SLVERR_EN    when defined, out-of-range accesses answer SLVERR
//                             (2'b10) instead of OKAY; data side effects unchanged.
//
// DATA_WIDTH must be 32 or 64; NUM_REGS must fit in the word-index space.
// ---------------------------------------------------------------------------

// One register with per-byte write enables.
module axi_lite_slave_regfile_reg #(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  output logic [DATA_WIDTH-1:0]   q_o
);
  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    for (int b = 0; b < NB; b++)
      if (we_i && wstrb_i[b]) q_d[b*8 +: 8] = wdata_i[b*8 +: 8];
  end

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) q_q <= RESET_VALUE;
    else       q_q <= q_d;

  assign q_o = q_q;
endmodule

module axi_lite_slave_regfile #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 6,
  parameter int                    NUM_REGS    = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                             axi_aclk,
  input  logic                             axi_areset,
  input  logic [ADDR_WIDTH-1:0]            s_axi_awaddr,
  input  logic [2:0]                       s_axi_awprot,
  input  logic                             s_axi_awvalid,
  output logic                             s_axi_awready,
  input  logic [DATA_WIDTH-1:0]            s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]          s_axi_wstrb,
  input  logic                             s_axi_wvalid,
  output logic                             s_axi_wready,
  output logic [1:0]                       s_axi_bresp,
  output logic                             s_axi_bvalid,
  input  logic                             s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]            s_axi_araddr,
  input  logic [2:0]                       s_axi_arprot,
  input  logic                             s_axi_arvalid,
  output logic                             s_axi_arready,
  output logic [DATA_WIDTH-1:0]            s_axi_rdata,
  output logic [1:0]                       s_axi_rresp,
  output logic                             s_axi_rvalid,
  input  logic                             s_axi_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0]   reg_out,
  output logic [NUM_REGS-1:0]              reg_wr_pulse
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int LSB   = $clog2(NB);
  localparam int IDX_W = ADDR_WIDTH - LSB;

  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXI_LITE_SLV_SLVERR_EN
  localparam logic [1:0] RESP_OOR  = 2'b10;
`else
  localparam logic [1:0] RESP_OOR  = 2'b00;
`endif

  typedef enum logic { W_IDLE, W_RESP } wstate_e;
  typedef enum logic { R_IDLE, R_DATA } rstate_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [NB-1:0]         strb;
  } wbeat_t;

  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return 32'(idx) < NUM_REGS;
  endfunction

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;

  // ---------------- write channel ----------------
  wstate_e             wstate_q;
  logic                awready_q, wready_q, bvalid_q;
  logic [1:0]          bresp_q;
  logic                aw_got_q, w_got_q;
  logic [IDX_W-1:0]    awidx_q;
  wbeat_t              wbeat_q;
  logic [NUM_REGS-1:0] pulse_q;

  logic                aw_fire, w_fire, commit, win;
  logic [IDX_W-1:0]    widx;
  wbeat_t              wbeat;
  logic [NUM_REGS-1:0] reg_we;

  assign aw_fire = s_axi_awvalid && awready_q;
  assign w_fire  = s_axi_wvalid  && wready_q;

  // Beats captured this edge bypass the holding registers so the commit
  // happens on the edge that completes the pair, whichever order they came in.
  assign widx  = aw_got_q ? awidx_q : s_axi_awaddr[ADDR_WIDTH-1:LSB];
  assign wbeat = w_got_q  ? wbeat_q : wbeat_t'{data: s_axi_wdata, strb: s_axi_wstrb};

  assign commit = (wstate_q == W_IDLE) && (aw_got_q || aw_fire) && (w_got_q || w_fire);
  assign win    = in_range(widx);

  always_comb begin
    reg_we = '0;
    for (int i = 0; i < NUM_REGS; i++)
      reg_we[i] = commit && win && (widx == IDX_W'(i));
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      awidx_q   <= '0;
      wbeat_q   <= '0;
      pulse_q   <= '0;
    end else begin
      pulse_q <= reg_we;
      case (wstate_q)
        W_IDLE: begin
          if (commit) begin
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= win ? RESP_OKAY : RESP_OOR;
            wstate_q  <= W_RESP;
          end else begin
            if (aw_fire) begin
              aw_got_q <= 1'b1;
              awidx_q  <= s_axi_awaddr[ADDR_WIDTH-1:LSB];
            end
            if (w_fire) begin
              w_got_q <= 1'b1;
              wbeat_q <= wbeat_t'{data: s_axi_wdata, strb: s_axi_wstrb};
            end
            // Each ready rises out of reset and drops once its beat is held.
            awready_q <= !(aw_got_q || aw_fire);
            wready_q  <= !(w_got_q  || w_fire);
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            wstate_q  <= W_IDLE;
          end
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  // ---------------- register bank ----------------
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    axi_lite_slave_regfile_reg #(
      .DATA_WIDTH  (DATA_WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_reg (
      .clk_i   (axi_aclk),
      .rst_i   (axi_areset),
      .we_i    (reg_we[g]),
      .wdata_i (wbeat.data),
      .wstrb_i (wbeat.strb),
      .q_o     (regs[g])
    );
  end

  // ---------------- read channel ----------------
  rstate_e               rstate_q;
  logic                  arready_q, rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;

  logic [IDX_W-1:0]      ridx;
  logic [DATA_WIDTH-1:0] rmux;

  assign ridx = s_axi_araddr[ADDR_WIDTH-1:LSB];

  // Out-of-range indices match no register and read as zero. Sampling the
  // current register outputs gives pre-write data on a same-edge write.
  always_comb begin
    rmux = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (ridx == IDX_W'(i)) rmux = regs[i];
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      case (rstate_q)
        R_IDLE: begin
          if (s_axi_arvalid && arready_q) begin
            rdata_q   <= rmux;
            rresp_q   <= in_range(ridx) ? RESP_OKAY : RESP_OOR;
            rvalid_q  <= 1'b1;
            arready_q <= 1'b0;
            rstate_q  <= R_DATA;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_axi_rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            rstate_q  <= R_IDLE;
          end
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  // Protection bits and sub-word address bits carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{s_axi_awprot, s_axi_arprot,
                           s_axi_awaddr[LSB-1:0], s_axi_araddr[LSB-1:0]};

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign reg_out       = regs;
  assign reg_wr_pulse  = pulse_q;
endmodule

// File: tb/tb_axi_lite_slave_regfile.sv
// Directed bench for axi_lite_slave_regfile: a vector table of single
// transactions plus hand-written sequences for ordering, back-pressure,
// same-edge read/write and reset in the middle of a response.
module tb_axi_lite_slave_regfile;
  localparam int          DW = 32;
  localparam int          AW = 7;   // one bit wider than needed so 0x40 is out of range
  localparam int          NR = 16;
  localparam logic [31:0] RV = 32'hC0DE_0000;
`ifdef AXI_LITE_SLV_SLVERR_EN
  localparam logic [1:0]  OOR = 2'b10;
`else
  localparam logic [1:0]  OOR = 2'b00;
`endif

  logic             clk, rst;
  logic [AW-1:0]    awaddr, araddr;
  logic             awvalid, awready, wvalid, wready, bvalid, bready;
  logic             arvalid, arready, rvalid, rready;
  logic [DW-1:0]    wdata, rdata;
  logic [3:0]       wstrb;
  logic [1:0]       bresp, rresp;
  logic [NR*DW-1:0] reg_out;
  logic [NR-1:0]    reg_wr_pulse;

  axi_lite_slave_regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .RESET_VALUE(RV)) dut (
    .axi_aclk(clk), .axi_areset(rst),
    .s_axi_awaddr(awaddr), .s_axi_awprot(3'b000), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arprot(3'b000), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [NR-1:0][DW-1:0] mdl;

  typedef struct {
    logic        wr;
    logic [6:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;    // write: new register value; read: rdata
    logic [1:0]  resp;
    logic [15:0] pulse;  // write only; zero means no register may change
  } vec_t;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic axi_write(input string nm, input logic [6:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [1:0] er, input logic [15:0] ep);
    int n = 0;
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b1;
    while (!(awready && wready) && n < 20) begin tick(); n++; end
    check({nm, "_ready_wait"}, 512'(n < 20), 512'(1));
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check({nm, "_bvalid"}, 512'(bvalid), 512'(1));
    check({nm, "_bresp"},  512'(bresp),  512'(er));
    check({nm, "_pulse"},  512'(reg_wr_pulse), 512'(ep));
    check({nm, "_regs"},   512'(reg_out), 512'(mdl));
    tick();
    bready = 1'b0;
    check({nm, "_bdone"},  512'(bvalid), 512'(0));
  endtask

  task automatic axi_read(input string nm, input logic [6:0] a, input logic [31:0] ed,
                          input logic [1:0] er);
    int n = 0;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    while (!arready && n < 20) begin tick(); n++; end
    check({nm, "_ar_wait"}, 512'(n < 20), 512'(1));
    tick();
    arvalid = 1'b0;
    check({nm, "_rvalid"}, 512'(rvalid), 512'(1));
    check({nm, "_rdata"},  512'(rdata),  512'(ed));
    check({nm, "_rresp"},  512'(rresp),  512'(er));
    tick();
    rready = 1'b0;
    check({nm, "_rdone"},  512'(rvalid), 512'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[14];
    vecs[0]  = '{1'b1, 7'h04, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 2'b00, 16'h0002};
    vecs[1]  = '{1'b0, 7'h04, 32'h0,        4'h0, 32'hDEADBEEF, 2'b00, 16'h0000};
    vecs[2]  = '{1'b1, 7'h08, 32'h12345678, 4'h3, 32'hC0DE5678, 2'b00, 16'h0004};
    vecs[3]  = '{1'b0, 7'h0A, 32'h0,        4'h0, 32'hC0DE5678, 2'b00, 16'h0000};
    vecs[4]  = '{1'b1, 7'h3C, 32'hA5A5A5A5, 4'hC, 32'hA5A50000, 2'b00, 16'h8000};
    vecs[5]  = '{1'b0, 7'h3F, 32'h0,        4'h0, 32'hA5A50000, 2'b00, 16'h0000};
    vecs[6]  = '{1'b1, 7'h08, 32'hFFFFFFFF, 4'h0, 32'hC0DE5678, 2'b00, 16'h0004};
    vecs[7]  = '{1'b0, 7'h08, 32'h0,        4'h0, 32'hC0DE5678, 2'b00, 16'h0000};
    vecs[8]  = '{1'b1, 7'h40, 32'h11111111, 4'hF, 32'h0,        OOR,   16'h0000};
    vecs[9]  = '{1'b0, 7'h40, 32'h0,        4'h0, 32'h0,        OOR,   16'h0000};
    vecs[10] = '{1'b0, 7'h7D, 32'h0,        4'h0, 32'h0,        OOR,   16'h0000};
    vecs[11] = '{1'b0, 7'h00, 32'h0,        4'h0, 32'hC0DE0000, 2'b00, 16'h0000};
    vecs[12] = '{1'b1, 7'h16, 32'h00FF0000, 4'h4, 32'hC0FF0000, 2'b00, 16'h0020};
    vecs[13] = '{1'b0, 7'h14, 32'h0,        4'h0, 32'hC0FF0000, 2'b00, 16'h0000};

    for (int i = 0; i < NR; i++) mdl[i] = RV;
    rst = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;

    // ---- reset state ----
    repeat (3) tick();
    check("rst_awready", 512'(awready), 512'(0));
    check("rst_arready", 512'(arready), 512'(0));
    check("rst_bvalid",  512'(bvalid),  512'(0));
    check("rst_rdata",   512'(rdata),   512'(0));
    check("rst_regs",    512'(reg_out), 512'(mdl));
    rst = 1'b0;
    check("rel_wready_pre", 512'(wready), 512'(0));
    tick();
    check("rel_awready", 512'(awready), 512'(1));
    check("rel_wready",  512'(wready),  512'(1));
    check("rel_arready", 512'(arready), 512'(1));
    check("rel_bv_rv",   512'({bvalid, rvalid}), 512'(0));

    // ---- vector table ----
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].wr) begin
        if (vecs[i].pulse != 0) mdl[vecs[i].addr[6:2]] = vecs[i].exp;
        axi_write($sformatf("v%0d", i), vecs[i].addr, vecs[i].data, vecs[i].strb,
                  vecs[i].resp, vecs[i].pulse);
      end else begin
        axi_read($sformatf("v%0d", i), vecs[i].addr, vecs[i].exp, vecs[i].resp);
      end
    end

    // ---- W before AW: byte merge into reg1 ----
    wdata = 32'h000000AA; wstrb = 4'h1; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    check("wfirst_wready", 512'(wready),  512'(0));
    check("wfirst_awrdy",  512'(awready), 512'(1));
    check("wfirst_bvalid", 512'(bvalid),  512'(0));
    tick(); tick();
    check("wfirst_wait_wready", 512'(wready), 512'(0));
    check("wfirst_wait_bvalid", 512'(bvalid), 512'(0));
    awaddr = 7'h04; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    mdl[1] = 32'hDEADBEAA;
    check("wfirst_bvalid1", 512'(bvalid), 512'(1));
    check("wfirst_pulse",   512'(reg_wr_pulse), 512'(16'h0002));
    check("wfirst_regs",    512'(reg_out), 512'(mdl));
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("wfirst_bdone", 512'(bvalid), 512'(0));
    check("wfirst_rdy",   512'({awready, wready}), 512'(2'b11));

    // ---- AW before W, then B back-pressure with a new AW pending ----
    awaddr = 7'h08; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("awfirst_awready", 512'(awready), 512'(0));
    check("awfirst_wready",  512'(wready),  512'(1));
    wdata = 32'h11223344; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    mdl[2] = 32'h11223344;
    check("awfirst_bvalid", 512'(bvalid), 512'(1));
    check("awfirst_pulse",  512'(reg_wr_pulse), 512'(16'h0004));
    awaddr = 7'h0C; awvalid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("bstall%0d_bvalid", k),  512'(bvalid),  512'(1));
      check($sformatf("bstall%0d_bresp", k),   512'(bresp),   512'(0));
      check($sformatf("bstall%0d_awready", k), 512'(awready), 512'(0));
      check($sformatf("bstall%0d_pulse", k),   512'(reg_wr_pulse), 512'(0));
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("bstall_bdone",   512'(bvalid),  512'(0));
    check("bstall_awready", 512'(awready), 512'(1));
    tick();
    awvalid = 1'b0;
    check("bstall_aw_taken", 512'(awready), 512'(0));
    wdata = 32'h0BADF00D; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    mdl[3] = 32'h0BADF00D;
    check("bstall_w2_bvalid", 512'(bvalid), 512'(1));
    check("bstall_w2_pulse",  512'(reg_wr_pulse), 512'(16'h0008));
    check("bstall_w2_regs",   512'(reg_out), 512'(mdl));
    bready = 1'b1;
    tick();
    bready = 1'b0;

    // ---- R back-pressure ----
    araddr = 7'h08; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    check("rstall_rvalid", 512'(rvalid), 512'(1));
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("rstall%0d_rvalid", k),  512'(rvalid),  512'(1));
      check($sformatf("rstall%0d_rdata", k),   512'(rdata),   512'(32'h11223344));
      check($sformatf("rstall%0d_arready", k), 512'(arready), 512'(0));
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check("rstall_rdone",   512'(rvalid),  512'(0));
    check("rstall_arready", 512'(arready), 512'(1));

    // ---- same-edge read and write of reg2: read sees old value ----
    araddr = 7'h08; arvalid = 1'b1;
    awaddr = 7'h08; awvalid = 1'b1; wdata = 32'h00000055; wstrb = 4'hF; wvalid = 1'b1;
    bready = 1'b1; rready = 1'b1;
    tick();
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    mdl[2] = 32'h00000055;
    check("same_rvalid", 512'(rvalid), 512'(1));
    check("same_rdata",  512'(rdata),  512'(32'h11223344));
    check("same_bvalid", 512'(bvalid), 512'(1));
    check("same_regs",   512'(reg_out), 512'(mdl));
    tick();
    bready = 1'b0; rready = 1'b0;

    // ---- reset while bvalid is high ----
    awaddr = 7'h10; awvalid = 1'b1; wdata = 32'h77777777; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check("mrst_bvalid_pre", 512'(bvalid), 512'(1));
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < NR; i++) mdl[i] = RV;
    check("mrst_bvalid",  512'(bvalid), 512'(0));
    check("mrst_readies", 512'({awready, wready, arready}), 512'(0));
    check("mrst_pulse",   512'(reg_wr_pulse), 512'(0));
    check("mrst_regs",    512'(reg_out), 512'(mdl));
    tick();
    rst = 1'b0;
    bready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("mrst_post%0d_bvalid", k), 512'(bvalid), 512'(0));
    end
    bready = 1'b0;
    axi_read("mrst_rd", 7'h10, RV, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
